lcd_text_driver: RTL and testbench

- Consumes the 32-character text frame produced by the calculator operation modules (add/subtract/etc. `textOut`).
- Continuously paints that frame onto a 16x2 HD44780-compatible character LCD in 8-bit mode.
- Performs the power-up init sequence, then refreshes both lines forever, snapshotting the text at the start of each frame.

---
 rtl/lcd_text_driver.sv | 185 ++++++++++++++++++
 tb/tb_lcd_text_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_driver.sv
// Paints a 32-character text frame onto a 16x2 HD44780 LCD (8-bit mode):
// power-up delay, init command sequence, then an endless two-line refresh.
module lcd_text_driver #(
  parameter int unsigned POWERUP_CYC    = 750000,
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned E_PULSE_CYC    = 12,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic [256:0] textIn,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic         LCD_E,
  output logic [7:0]   LCD_DB,
  output logic         ready,
  output logic         frame_done
);

  typedef enum logic [2:0] {
    S_POWERUP, S_INIT, S_FRAME_START, S_ADDR1,
    S_LINE1, S_ADDR2, S_LINE2, S_FRAME_END
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD, PH_WAIT} phase_t;

  state_t         state_q, state_d;
  phase_t         phase_q, phase_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [4:0]     idx_q, idx_d;
  logic [255:0]   snap_q, snap_d;
  logic           rs_q, rs_d;
  logic [7:0]     db_q, db_d;
  logic           e_q, e_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;

  logic           writing;
  logic           write_done;
  logic [31:0]    wait_len;
  logic [7:0]     line_char;
  logic [7:0]     init_byte;

  logic           unused_textin_msb;
  assign unused_textin_msb = textIn[256];

  assign writing  = state_q inside {S_INIT, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2};
  // The byte on the bus during WAIT is the one just written, so it selects the wait length.
  assign wait_len = (!rs_q && db_q == 8'h01) ? CLEAR_WAIT_CYC : CMD_WAIT_CYC;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q + 32'd1;
    idx_d      = idx_q;
    snap_d     = snap_q;
    rs_d       = rs_q;
    db_d       = db_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    write_done = 1'b0;
    line_char  = 8'h00;
    init_byte  = 8'h00;

    if (writing) begin
      unique case (phase_q)
        PH_SETUP: if (cnt_q == SETUP_CYC - 1) begin
          phase_d = PH_PULSE;
          cnt_d   = '0;
        end
        PH_PULSE: if (cnt_q == E_PULSE_CYC - 1) begin
          phase_d = PH_HOLD;
          cnt_d   = '0;
        end
        PH_HOLD: begin
          phase_d = PH_WAIT;
          cnt_d   = '0;
        end
        PH_WAIT: if (cnt_q == wait_len - 1) begin
          phase_d    = PH_SETUP;
          cnt_d      = '0;
          write_done = 1'b1;
        end
        default: ;
      endcase
    end

    unique case (state_q)
      S_POWERUP: if (cnt_q == POWERUP_CYC - 1) begin
        state_d = S_INIT;
        phase_d = PH_SETUP;
        cnt_d   = '0;
        idx_d   = '0;
      end
      S_INIT: if (write_done) begin
        if (idx_q == 5'd5) begin
          state_d = S_FRAME_START;
          ready_d = 1'b1;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      S_FRAME_START: begin
        snap_d  = textIn[255:0];
        state_d = S_ADDR1;
        phase_d = PH_SETUP;
        cnt_d   = '0;
        idx_d   = '0;
      end
      S_ADDR1: if (write_done) state_d = S_LINE1;
      S_LINE1: if (write_done) begin
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd15) state_d = S_ADDR2;
      end
      S_ADDR2: if (write_done) state_d = S_LINE2;
      // Index parks at 31 through FRAME_END; FRAME_START rewinds it.
      S_LINE2: if (write_done) begin
        if (idx_q == 5'd31) state_d = S_FRAME_END;
        else                idx_d   = idx_q + 5'd1;
      end
      S_FRAME_END: begin
        done_d  = 1'b1;
        state_d = S_FRAME_START;
        cnt_d   = '0;
      end
      default: state_d = S_POWERUP;
    endcase

    // Bus contents are loaded as each write enters SETUP and held until the next one.
    line_char = snap_d[{~idx_d, 3'b000} +: 8];
    unique case (idx_d)
      5'd0, 5'd1, 5'd2: init_byte = 8'h38;
      5'd3:             init_byte = 8'h0C;
      5'd4:             init_byte = 8'h01;
      default:          init_byte = 8'h06;
    endcase
    if (phase_d == PH_SETUP) begin
      unique case (state_d)
        S_INIT:  begin rs_d = 1'b0; db_d = init_byte; end
        S_ADDR1: begin rs_d = 1'b0; db_d = 8'h80;     end
        S_ADDR2: begin rs_d = 1'b0; db_d = 8'hC0;     end
        S_LINE1,
        S_LINE2: begin rs_d = 1'b1; db_d = line_char; end
        default: ;
      endcase
    end
    e_d = (phase_d == PH_PULSE) &&
          (state_d inside {S_INIT, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2});
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= S_POWERUP;
      phase_q <= PH_SETUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      rs_q    <= 1'b0;
      db_q    <= '0;
      e_q     <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      e_q     <= e_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign LCD_RS     = rs_q;
  assign LCD_RW     = 1'b0;
  assign LCD_E      = e_q;
  assign LCD_DB     = db_q;
  assign ready      = ready_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_lcd_text_driver.sv
// Self-checking bench for lcd_text_driver with shortened timing parameters.
module tb_lcd_text_driver;

  logic         Clk;
  logic         reset;
  logic [256:0] textIn;
  logic         LCD_RS, LCD_RW, LCD_E, ready, frame_done;
  logic [7:0]   LCD_DB;

  lcd_text_driver #(
    .POWERUP_CYC   (20),
    .SETUP_CYC     (2),
    .E_PULSE_CYC   (3),
    .CMD_WAIT_CYC  (5),
    .CLEAR_WAIT_CYC(10)
  ) dut (
    .Clk       (Clk),
    .reset     (reset),
    .textIn    (textIn),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .LCD_E     (LCD_E),
    .LCD_DB    (LCD_DB),
    .ready     (ready),
    .frame_done(frame_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       rs;
    logic [7:0] db;
  } vec_t;

  typedef struct {
    logic       rs;
    logic [7:0] db;
    int         cyc;
    logic       rdy;
  } wr_t;

  typedef struct {
    int cyc;
    int nwr;
  } done_t;

  vec_t  exp_tab[$];
  wr_t   writes[$];
  done_t dones[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic rw_bad = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_frame(input logic [255:0] t);
    exp_tab.push_back('{rs: 1'b0, db: 8'h80});
    for (int k = 0; k < 16; k++) exp_tab.push_back('{rs: 1'b1, db: t[255-8*k -: 8]});
    exp_tab.push_back('{rs: 1'b0, db: 8'hC0});
    for (int k = 16; k < 32; k++) exp_tab.push_back('{rs: 1'b1, db: t[255-8*k -: 8]});
  endtask

  // Bus monitor: samples 1 time unit after each rising edge.
  initial begin
    logic       prev_e, prev_done, in_pulse, stab_ok;
    logic [8:0] d1, d2, cap;
    int         hi_len, done_len;
    prev_e = 0; prev_done = 0; in_pulse = 0; stab_ok = 0;
    d1 = '0; d2 = '0; cap = '0; hi_len = 0; done_len = 0;
    forever begin
      @(posedge Clk); #1;
      cyc++;
      if (LCD_RW !== 1'b0) rw_bad = 1'b1;
      if (reset) begin
        in_pulse = 0; prev_e = 0; prev_done = 0; done_len = 0;
      end else begin
        if (LCD_E && !prev_e) begin
          writes.push_back('{rs: LCD_RS, db: LCD_DB, cyc: cyc, rdy: ready});
          cap      = {LCD_RS, LCD_DB};
          stab_ok  = (cap == d1) && (cap == d2);
          in_pulse = 1; hi_len = 1;
        end else if (LCD_E && in_pulse) begin
          hi_len++;
          if ({LCD_RS, LCD_DB} != cap) stab_ok = 0;
        end else if (!LCD_E && prev_e && in_pulse) begin
          if ({LCD_RS, LCD_DB} != cap) stab_ok = 0;
          check("e_high_len", hi_len, 3);
          check("rs_db_stable", {31'd0, stab_ok}, 1);
          in_pulse = 0;
        end
        if (frame_done) begin
          if (!prev_done) dones.push_back('{cyc: cyc, nwr: writes.size()});
          done_len++;
        end else if (prev_done) begin
          check("frame_done_width", done_len, 1);
          done_len = 0;
        end
        prev_e = LCD_E; prev_done = frame_done;
      end
      d2 = d1; d1 = {LCD_RS, LCD_DB};
    end
  end

  initial begin
    logic [256:0] text1, text2;
    int rel, base, gap, budget;
    logic changed;

    text1 = {1'b0, "Subtraction     Subs 2 Numbers  "};
    text2 = {1'b0, "The Diff is:   |0A              "};

    exp_tab.push_back('{rs: 1'b0, db: 8'h38});
    exp_tab.push_back('{rs: 1'b0, db: 8'h38});
    exp_tab.push_back('{rs: 1'b0, db: 8'h38});
    exp_tab.push_back('{rs: 1'b0, db: 8'h0C});
    exp_tab.push_back('{rs: 1'b0, db: 8'h01});
    exp_tab.push_back('{rs: 1'b0, db: 8'h06});
    add_frame(text1[255:0]);
    add_frame(text1[255:0]);
    add_frame(text2[255:0]);

    reset  = 1'b1;
    textIn = text1;
    repeat (3) @(posedge Clk);
    #2;
    check("rst_rs", {31'd0, LCD_RS}, 0);
    check("rst_e", {31'd0, LCD_E}, 0);
    check("rst_db", {24'd0, LCD_DB}, 0);
    check("rst_ready", {31'd0, ready}, 0);
    check("rst_frame_done", {31'd0, frame_done}, 0);

    @(negedge Clk);
    rel   = cyc;
    reset = 1'b0;
    changed = 1'b0;
    budget  = 3000;
    while (dones.size() < 3 && budget > 0) begin
      @(negedge Clk);
      budget--;
      if (!changed && writes.size() >= 45) begin
        textIn  = text2;
        changed = 1'b1;
      end
    end
    check("three_frames_timeout", {31'd0, dones.size() >= 3}, 1);

    if (writes.size() > 0)
      check("first_e_after_powerup",
            {31'd0, (writes[0].cyc - rel >= 22) && (writes[0].cyc - rel <= 24)}, 1);

    for (int i = 0; i < 108; i++) begin
      if (i < writes.size()) begin
        check($sformatf("wr%0d_rs", i), {31'd0, writes[i].rs}, {31'd0, exp_tab[i].rs});
        check($sformatf("wr%0d_db", i), {24'd0, writes[i].db}, {24'd0, exp_tab[i].db});
        check($sformatf("wr%0d_ready", i), {31'd0, writes[i].rdy}, {31'd0, i >= 6});
        if (i > 0) begin
          gap = (exp_tab[i-1].rs == 1'b0 && exp_tab[i-1].db == 8'h01) ? 16 : 11;
          if (i == 6) gap += 1;
          if (i == 40 || i == 74) gap += 2;
          check($sformatf("wr%0d_gap", i), writes[i].cyc - writes[i-1].cyc, gap);
        end
      end else begin
        check($sformatf("wr%0d_missing", i), 0, 1);
      end
    end

    if (dones.size() >= 3) begin
      check("done0_writes", dones[0].nwr, 40);
      check("done1_writes", dones[1].nwr, 74);
      check("done2_writes", dones[2].nwr, 108);
      check("frame_period_1", dones[1].cyc - dones[0].cyc, 376);
      check("frame_period_2", dones[2].cyc - dones[1].cyc, 376);
    end

    // Reset in the middle of a data strobe.
    budget = 500;
    while (budget > 0) begin
      @(posedge Clk); #2;
      budget--;
      if (LCD_E && LCD_RS) break;
    end
    check("data_strobe_seen", {31'd0, LCD_E && LCD_RS}, 1);
    reset = 1'b1;
    #1;
    check("midrst_e", {31'd0, LCD_E}, 0);
    check("midrst_ready", {31'd0, ready}, 0);
    check("midrst_db", {24'd0, LCD_DB}, 0);
    check("midrst_rs", {31'd0, LCD_RS}, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    rel   = cyc;
    base  = writes.size();
    reset = 1'b0;
    budget = 400;
    while (writes.size() < base + 7 && budget > 0) begin
      @(negedge Clk);
      budget--;
    end
    check("reinit_timeout", {31'd0, writes.size() >= base + 7}, 1);
    if (writes.size() >= base + 7) begin
      check("reinit_first_e",
            {31'd0, (writes[base].cyc - rel >= 22) && (writes[base].cyc - rel <= 24)}, 1);
      for (int i = 0; i < 7; i++) begin
        check($sformatf("reinit%0d_rs", i), {31'd0, writes[base+i].rs}, {31'd0, exp_tab[i].rs});
        check($sformatf("reinit%0d_db", i), {24'd0, writes[base+i].db}, {24'd0, exp_tab[i].db});
        check($sformatf("reinit%0d_ready", i), {31'd0, writes[base+i].rdy}, {31'd0, i >= 6});
      end
    end

    check("rw_always_low", {31'd0, rw_bad}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
